// File: rtl/game_ctrl_if.sv
// game_ctrl_if: pixel and button inputs plus status/score outputs
// exchanged between the display pipeline and the game controller.
interface game_ctrl_if;
  logic        fresh;
  logic        START;
  logic        RESET;
  logic        dino_px;
  logic        obstacle_px;
  logic        game_status;
  logic        game_over;
  logic        hit;
  logic [15:0] score;

  modport master (
    output fresh,
    output START,
    output RESET,
    output dino_px,
    output obstacle_px,
    input  game_status,
    input  game_over,
    input  hit,
    input  score
  );

  modport slave (
    input  fresh,
    input  START,
    input  RESET,
    input  dino_px,
    input  obstacle_px,
    output game_status,
    output game_over,
    output hit,
    output score
  );
endinterface

// File: rtl/game_ctrl.sv
// game_ctrl: frame-synchronous IDLE/RUN/OVER controller for the dino runner,
// with per-frame overlap counting and a saturating 4-digit BCD score.
module game_ctrl_edge #(
  parameter bit FALL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic edge_o
);
  logic s1_q;
  logic s2_q;
  logic p_q;
  logic edge_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      p_q    <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      p_q    <= s2_q;
      edge_q <= FALL ? (p_q & ~s2_q)
                     : (s2_q & ~p_q);
    end
  end

  assign edge_o = edge_q;
endmodule

module game_ctrl #(
  parameter int unsigned COLLIDE_MIN = 4,
  parameter int unsigned SCORE_DIV   = 6
) (
  input logic        clk,
  input logic        RESET_N,
  game_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OVER = 2'd2
  } state_e;

  localparam logic [7:0] CMIN = 8'(COLLIDE_MIN);
  localparam logic [7:0] DTOP = 8'(SCORE_DIV - 1);

  logic frame_end;
  logic start_edge;
  logic reset_edge;

  game_ctrl_edge #(.FALL(1'b1)) u_fresh (
    .clk    (clk),
    .rst_n  (RESET_N),
    .d_i    (bus.fresh),
    .edge_o (frame_end)
  );

  game_ctrl_edge #(.FALL(1'b0)) u_start (
    .clk    (clk),
    .rst_n  (RESET_N),
    .d_i    (bus.START),
    .edge_o (start_edge)
  );

  game_ctrl_edge #(.FALL(1'b0)) u_reset (
    .clk    (clk),
    .rst_n  (RESET_N),
    .d_i    (bus.RESET),
    .edge_o (reset_edge)
  );

  state_e      state_q;
  state_e      state_d;
  logic        spend_q;
  logic        spend_d;
  logic        rpend_q;
  logic        rpend_d;
  logic [7:0]  hc_q;
  logic [7:0]  hc_d;
  logic [7:0]  div_q;
  logic [7:0]  div_d;
  logic [15:0] score_q;
  logic [15:0] score_d;
  logic        hit_q;
  logic        hit_d;
  logic        status_q;
  logic        over_q;

  // Per-digit carry; 9999 is a hard ceiling, never wraps to 0000.
  function automatic logic [15:0] bcd_inc(
    input logic [15:0] v
  );
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    bcd_inc = (v == 16'h9999) ? v : r;
  endfunction

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    div_d   = div_q;
    hit_d   = 1'b0;
    hc_d    = hc_q;
    // Clear before set: an edge coincident with frame_end survives.
    spend_d = (spend_q & ~frame_end) | start_edge;
    rpend_d = (rpend_q & ~frame_end) | reset_edge;

    if (frame_end) begin
      hc_d = 8'd0;
    end else if (state_q == S_RUN && bus.dino_px &&
                 bus.obstacle_px && hc_q != 8'hFF) begin
      hc_d = hc_q + 8'd1;
    end

    if (frame_end) begin
      if (rpend_q) begin
        state_d = S_IDLE;
        score_d = 16'h0000;
        div_d   = 8'd0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (spend_q) begin
              state_d = S_RUN;
              score_d = 16'h0000;
              div_d   = 8'd0;
            end
          end
          S_RUN: begin
            if (hc_q >= CMIN) begin
              state_d = S_OVER;
              hit_d   = 1'b1;
            end else if (div_q >= DTOP) begin
              div_d   = 8'd0;
              score_d = bcd_inc(score_q);
            end else begin
              div_d   = div_q + 8'd1;
            end
          end
          S_OVER: begin
            if (spend_q) begin
              state_d = S_RUN;
              score_d = 16'h0000;
              div_d   = 8'd0;
            end
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      spend_q  <= 1'b0;
      rpend_q  <= 1'b0;
      hc_q     <= 8'd0;
      div_q    <= 8'd0;
      score_q  <= 16'h0000;
      hit_q    <= 1'b0;
      status_q <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      spend_q  <= spend_d;
      rpend_q  <= rpend_d;
      hc_q     <= hc_d;
      div_q    <= div_d;
      score_q  <= score_d;
      hit_q    <= hit_d;
      status_q <= (state_d == S_RUN);
      over_q   <= (state_d == S_OVER);
    end
  end

  assign bus.game_status = status_q;
  assign bus.game_over   = over_q;
  assign bus.hit         = hit_q;
  assign bus.score       = score_q;
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: frame-level vector table, hand-written timing sequences and
// randomized frames checked every clock against a frame-rule model.
module tb_game_ctrl;
  logic clk = 1'b0;
  logic RESET_N = 1'b0;

  game_ctrl_if b0();
  game_ctrl_if b1();

  game_ctrl #(.COLLIDE_MIN(4), .SCORE_DIV(6)) dut (
    .clk     (clk),
    .RESET_N (RESET_N),
    .bus     (b0.slave)
  );

  game_ctrl #(.COLLIDE_MIN(4), .SCORE_DIV(1)) dut_sat (
    .clk     (clk),
    .RESET_N (RESET_N),
    .bus     (b1.slave)
  );

  assign b1.fresh       = b0.fresh;
  assign b1.START       = b0.START;
  assign b1.RESET       = b0.RESET;
  assign b1.dino_px     = b0.dino_px;
  assign b1.obstacle_px = b0.obstacle_px;

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int hit_seen = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: raw input history plus frame-level game rules
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_OVER = 2;

  bit qf[$];
  bit qs[$];
  bit qr[$];
  int m_state;
  bit m_sp;
  bit m_rp;
  bit m_hit;
  int m_hits;
  int m_sc[2];
  int m_fr[2];
  int divs[2] = '{6, 1};

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic m_zero_score();
    for (int k = 0; k < 2; k++) begin
      m_sc[k] = 0;
      m_fr[k] = 0;
    end
  endtask

  task automatic m_step();
    bit fe, se, re;
    int hits_old;
    if (!RESET_N) begin
      qf.delete(); qs.delete(); qr.delete();
      repeat (5) begin
        qf.push_back(1'b0);
        qs.push_back(1'b0);
        qr.push_back(1'b0);
      end
      m_state = M_IDLE;
      m_sp = 0; m_rp = 0; m_hit = 0; m_hits = 0;
      m_zero_score();
      return;
    end
    qf.push_front(b0.fresh);
    qs.push_front(b0.START);
    qr.push_front(b0.RESET);
    void'(qf.pop_back());
    void'(qs.pop_back());
    void'(qr.pop_back());
    // strobes visible to the controller at this edge (3-clk input latency)
    fe = qf[4] && !qf[3];
    se = !qs[4] && qs[3];
    re = !qr[4] && qr[3];
    hits_old = m_hits;
    if (fe) m_hits = 0;
    else if (m_state == M_RUN && b0.dino_px && b0.obstacle_px &&
             m_hits < 255) m_hits++;
    m_hit = 0;
    if (fe) begin
      if (m_rp) begin
        m_state = M_IDLE;
        m_zero_score();
      end else if (m_state == M_IDLE && m_sp) begin
        m_state = M_RUN;
        m_zero_score();
      end else if (m_state == M_RUN && hits_old >= 4) begin
        m_state = M_OVER;
        m_hit = 1;
      end else if (m_state == M_RUN) begin
        for (int k = 0; k < 2; k++) begin
          m_fr[k]++;
          if (m_fr[k] == divs[k]) begin
            m_fr[k] = 0;
            if (m_sc[k] < 9999) m_sc[k]++;
          end
        end
      end else if (m_state == M_OVER && m_sp) begin
        m_state = M_RUN;
        m_zero_score();
      end
    end
    m_sp = (m_sp && !fe) || se;
    m_rp = (m_rp && !fe) || re;
  endtask

  always @(posedge clk) begin
    bit r, o;
    m_step();
    #1;
    r = (m_state == M_RUN);
    o = (m_state == M_OVER);
    check("cycle_model",
          {b0.game_status, b0.game_over, b0.hit,
           b1.game_status, b1.game_over, b1.hit,
           b0.score, b1.score},
          {r, o, m_hit, r, o, m_hit,
           to_bcd(m_sc[0]), to_bcd(m_sc[1])});
    if (b0.hit === 1'b1) hit_seen++;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      b0.fresh = 1'b0;
      b0.START = 1'b0;
      b0.RESET = 1'b0;
      b0.dino_px = 1'b0;
      b0.obstacle_px = 1'b0;
    end
  endtask

  task automatic do_frame(input int hi, input int lo, input int st,
                          input int rs, input int ov, input bit rnd);
    int h;
    h = (hi < ov) ? ov : hi;
    for (int i = 0; i < h; i++) begin
      @(negedge clk);
      b0.fresh = 1'b1;
      b0.START = (st >= 0 && i >= st && i < st + 2);
      b0.RESET = (rs >= 0 && i >= rs && i < rs + 2);
      if (rnd) begin
        b0.dino_px = 1'($urandom_range(0, 1));
        b0.obstacle_px = 1'($urandom_range(0, 1));
      end else begin
        b0.dino_px = (i < ov);
        b0.obstacle_px = (i < ov);
      end
    end
    for (int i = 0; i < lo; i++) begin
      @(negedge clk);
      b0.fresh = 1'b0;
      b0.START = 1'b0;
      b0.RESET = 1'b0;
      b0.dino_px = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      b0.obstacle_px = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  typedef struct {
    int          st;
    int          rs;
    int          ov;
    bit          status;
    bit          over;
    logic [15:0] score;
  } vec_t;

  vec_t vec[15];

  initial begin
    int hs;
    int hi, lo, st, rs;
    vec[0]  = '{-1, -1,  0, 1'b0, 1'b0, 16'h0000};
    vec[1]  = '{-1, -1,  5, 1'b0, 1'b0, 16'h0000};
    vec[2]  = '{ 2, -1,  0, 1'b1, 1'b0, 16'h0000};
    vec[3]  = '{-1, -1,  3, 1'b1, 1'b0, 16'h0000};
    vec[4]  = '{-1, -1,  0, 1'b1, 1'b0, 16'h0000};
    vec[5]  = '{-1, -1,  0, 1'b1, 1'b0, 16'h0000};
    vec[6]  = '{-1, -1,  0, 1'b1, 1'b0, 16'h0000};
    vec[7]  = '{-1, -1,  0, 1'b1, 1'b0, 16'h0000};
    vec[8]  = '{-1, -1,  0, 1'b1, 1'b0, 16'h0001};
    vec[9]  = '{-1, -1,  4, 1'b0, 1'b1, 16'h0001};
    vec[10] = '{-1, -1, 20, 1'b0, 1'b1, 16'h0001};
    vec[11] = '{ 2, -1,  0, 1'b1, 1'b0, 16'h0000};
    vec[12] = '{ 2,  2,  0, 1'b0, 1'b0, 16'h0000};
    vec[13] = '{-1,  2,  0, 1'b0, 1'b0, 16'h0000};
    vec[14] = '{ 2, -1,  0, 1'b1, 1'b0, 16'h0000};

    b0.fresh = 1'b0;
    b0.START = 1'b0;
    b0.RESET = 1'b0;
    b0.dino_px = 1'b0;
    b0.obstacle_px = 1'b0;
    repeat (3) @(negedge clk);
    RESET_N = 1'b1;

    // reset asserted mid-frame, released with fresh low
    @(negedge clk);
    b0.fresh = 1'b1;
    repeat (3) @(negedge clk);
    RESET_N = 1'b0;
    #1;
    check("reset_state",
          {b0.game_status, b0.game_over, b0.hit, b0.score}, 64'd0);
    repeat (2) @(negedge clk);
    b0.fresh = 1'b0;
    @(negedge clk);
    RESET_N = 1'b1;
    idle(6);
    for (int f = 0; f < 3; f++) begin
      do_frame(8, 8, -1, -1, 0, 1'b0);
      check("idle_after_reset",
            {b0.game_status, b0.game_over, b0.score}, 64'd0);
    end

    for (int i = 0; i < $size(vec); i++) begin
      do_frame(8, 8, vec[i].st, vec[i].rs, vec[i].ov, 1'b0);
      check($sformatf("vec%0d_status", i), b0.game_status, vec[i].status);
      check($sformatf("vec%0d_over", i), b0.game_over, vec[i].over);
      check($sformatf("vec%0d_score", i), b0.score, vec[i].score);
    end

    // START to RUN: status rises exactly 4 clk after fresh falls
    do_frame(8, 8, -1, 2, 0, 1'b0);
    check("reset_to_idle", b0.game_status, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b0.fresh = 1'b1;
      b0.START = (i == 3 || i == 4);
    end
    @(negedge clk);
    b0.fresh = 1'b0;
    b0.START = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("start_lat_clk%0d", k), b0.game_status, (k >= 4));
    end
    repeat (7) do_frame(8, 8, -1, -1, 0, 1'b0);
    check("score_before_hit", b0.score, 16'h0001);

    // collision: hit pulses once on the 4th clk, score frozen
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b0.fresh = 1'b1;
      b0.dino_px = (i < 4);
      b0.obstacle_px = (i < 4);
    end
    @(negedge clk);
    b0.fresh = 1'b0;
    b0.dino_px = 1'b0;
    b0.obstacle_px = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("hit_clk%0d", k), b0.hit, (k == 4));
    end
    check("over_after_hit", {b0.game_status, b0.game_over}, 2'b01);
    repeat (2) do_frame(8, 8, -1, -1, 0, 1'b0);
    check("score_frozen", b0.score, 16'h0001);

    // overlap ignored in OVER, then restart clears score
    hs = hit_seen;
    do_frame(8, 8, -1, -1, 500, 1'b0);
    check("over_no_hit", hit_seen, hs);
    check("over_holds", b0.game_over, 1'b1);
    do_frame(8, 8, 2, -1, 0, 1'b0);
    check("restart_run", {b0.game_status, b0.score}, {1'b1, 16'h0000});

    repeat (60) do_frame(8, 8, -1, -1, 0, 1'b0);
    check("score_60_frames", b0.score, 16'h0010);

    // saturation on the SCORE_DIV=1 instance
    repeat (10005) do_frame(2, 2, -1, -1, 0, 1'b0);
    idle(5);
    check("sat_9999", b1.score, 16'h9999);
    check("div6_long_run", b0.score, 16'h1677);
    for (int f = 0; f < 20; f++) begin
      do_frame(2, 2, -1, -1, 0, 1'b0);
      check("sat_hold", b1.score, 16'h9999);
    end
    idle(5);
    check("div6_after_sat", b0.score, 16'h1680);

    // randomized frames against the model
    @(negedge clk);
    RESET_N = 1'b0;
    @(negedge clk);
    RESET_N = 1'b1;
    idle(4);
    for (int f = 0; f < 300; f++) begin
      hi = $urandom_range(2, 12);
      lo = $urandom_range(2, 10);
      st = ($urandom_range(0, 2) == 0) ? $urandom_range(0, hi - 2) : -1;
      rs = ($urandom_range(0, 7) == 0) ? $urandom_range(0, hi - 2) : -1;
      do_frame(hi, lo, st, rs, 0, 1'b1);
    end
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
